// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
//
// Shared definitions for the CPU register bank write-side logic.
//
//   NUM_REGS    number of architectural registers in the bank
//   REG_ADDR_W  register index width
//   REG_DATA_W  register data width
//   ZERO_REG    index of the hard-wired zero register (used only when the
//               REGBANK_WQ_XZR_EN build option is defined)
//   wb_entry_t  one pending writeback: destination index plus data
//   is_zero_reg helper that flags a destination equal to ZERO_REG
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int ZERO_REG   = 31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] reg_idx);
        return reg_idx == REG_ADDR_W'(ZERO_REG);
    endfunction

endpackage

// File: rtl/regbank_fwd_match.sv
// -----------------------------------------------------------------------------
// regbank_fwd_match
//
// Forwarding lookup for one decode read port. Scans the pending writeback
// entries and returns the data of the youngest entry whose destination
// matches the query index.
//
// Entries arrive already ordered by age: index 0 is the oldest (the head of
// the write queue), index DEPTH-1 the youngest possible slot. i_valid marks
// which of those age slots currently hold a pending entry.
//
// Ports:
//   i_qry    query register index
//   i_entry  age-ordered pending entries (oldest first)
//   i_valid  per-slot valid flags, same ordering as i_entry
//   o_hit    at least one valid entry matches i_qry
//   o_data   data of the youngest matching entry, 0 when there is no match
// -----------------------------------------------------------------------------
module regbank_fwd_match
    import regbank_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_ADDR_W-1:0] i_qry,
    input  wb_entry_t             i_entry [DEPTH],
    input  logic [DEPTH-1:0]      i_valid,
    output logic                  o_hit,
    output logic [REG_DATA_W-1:0] o_data
);

    // Walking oldest to youngest, a later match overwrites an earlier one,
    // so the value left after the loop belongs to the youngest match.
    always_comb begin
        // NOTE: combinational outputs get a default before any conditional
        // assignment so no path leaves them holding a value (no latch), and
        // blocking '=' is used so the in-loop overwrite order is meaningful.
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_valid[k] && (i_entry[k].addr == i_qry)) begin
                o_hit  = 1'b1;
                o_data = i_entry[k].data;
            end
        end
    end

endmodule

// File: rtl/regbank_write_queue.sv
// -----------------------------------------------------------------------------
// regbank_write_queue
//
// Write-side front end for the 32 x 64-bit register bank. Writeback results
// from the ALU and the memory load unit are accepted over valid/ready
// handshakes, buffered in a DEPTH-entry in-order FIFO and committed through
// the bank's single write port at up to one write per cycle. Two forwarding
// lookups let decode read ports see values that are queued but not yet
// committed.
//
// Build option:
//   REGBANK_WQ_XZR_EN  when defined, register 31 is a zero register: requests
//                      to it are handshaken but dropped, and forwarding
//                      queries for it never hit.
//
// Parameters:
//   DEPTH   FIFO entries (power of 2, at least 2)
//   DATA_W  write data width (must equal REG_DATA_W)
//   ADDR_W  register index width (must equal REG_ADDR_W)
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   alu_valid/ready/reg/data    ALU writeback handshake
//   mem_valid/ready/reg/data    load-unit writeback handshake (has priority)
//   write, write_register,
//   write_data                  bank write port, driven from the FIFO head
//   qry_reg1/2                  forwarding queries (bank read indices)
//   fwd_hit1/2, fwd_data1/2     forwarding results, youngest match wins
//   level, empty                FIFO occupancy
// -----------------------------------------------------------------------------
module regbank_write_queue
    import regbank_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_reg,
    input  logic [DATA_W-1:0]       alu_data,

    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_W-1:0]       mem_reg,
    input  logic [DATA_W-1:0]       mem_data,

    output logic                    write,
    output logic [ADDR_W-1:0]       write_register,
    output logic [DATA_W-1:0]       write_data,

    input  logic [ADDR_W-1:0]       qry_reg1,
    input  logic [ADDR_W-1:0]       qry_reg2,
    output logic                    fwd_hit1,
    output logic [DATA_W-1:0]       fwd_data1,
    output logic                    fwd_hit2,
    output logic [DATA_W-1:0]       fwd_data2,

    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake and push/pop decisions
    // -------------------------------------------------------------------------
    logic             w_pop;
    logic [CNT_W-1:0] w_free;
    logic             w_mem_acc;
    logic             w_alu_acc;
    logic             w_mem_push;
    logic             w_alu_push;
    wb_entry_t        w_mem_entry;
    wb_entry_t        w_alu_entry;

    // The bank always accepts, so the head leaves on every edge the queue is
    // non-empty. That departing slot is counted as free this cycle, which is
    // why a full queue can still take one new entry.
    assign w_pop  = (r_count != '0);
    assign w_free = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);

    // The load unit gets the first free slot; the ALU only takes a slot that
    // is left over. mem_ready never looks at alu_valid, and alu_ready looks
    // only at mem_valid, never at either payload.
    assign mem_ready = (w_free >= CNT_W'(1));
    assign alu_ready = (w_free >= CNT_W'(2)) |
                       ((w_free >= CNT_W'(1)) & ~mem_valid);

    assign w_mem_acc = mem_valid & mem_ready;
    assign w_alu_acc = alu_valid & alu_ready;

`ifdef REGBANK_WQ_XZR_EN
    // Writes to the zero register complete the handshake but are dropped.
    // Ready above is computed as if they were stored, so ready never depends
    // on the destination index.
    assign w_mem_push = w_mem_acc & ~is_zero_reg(mem_reg);
    assign w_alu_push = w_alu_acc & ~is_zero_reg(alu_reg);
`else
    assign w_mem_push = w_mem_acc;
    assign w_alu_push = w_alu_acc;
`endif

    assign w_mem_entry = '{addr: mem_reg, data: mem_data};
    assign w_alu_entry = '{addr: alu_reg, data: alu_data};

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the plain
    // increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking '<=' so
            // every register samples values from before this edge, whatever
            // the statement order.
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_tail  <= r_tail + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
            r_count <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push)
                     - CNT_W'(w_pop);
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // The load entry goes in first so it is older than an ALU entry accepted
    // on the same edge; the ALU entry then lands one slot further on, or at
    // the tail itself when no load was stored.
    // NOTE: the storage array has no reset. Slots are only ever read when the
    // occupancy count says they hold a pushed entry, so clearing them buys
    // nothing and would turn a plain RAM into a reset-able flop array.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_mem[r_tail] <= w_mem_entry;
        end
        if (w_alu_push) begin
            r_mem[r_tail + PTR_W'(w_mem_push)] <= w_alu_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Bank write port: the head entry, presented combinationally
    // -------------------------------------------------------------------------
    assign write          = w_pop;
    assign write_register = r_mem[r_head].addr;
    assign write_data     = r_mem[r_head].data;

    assign level = r_count;
    assign empty = (r_count == '0);

    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    // Rotate the circular storage into age order (slot 0 = head) so the match
    // logic sees a fixed oldest-to-youngest layout. The head is included even
    // though it is being written this cycle: the bank read happens in the
    // same cycle and would still return the old value.
    wb_entry_t        w_ord [DEPTH];
    logic [DEPTH-1:0] w_ord_valid;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_ord[k]       = r_mem[r_head + PTR_W'(k)];
            w_ord_valid[k] = (CNT_W'(k) < r_count);
        end
    end

    logic              w_hit1;
    logic              w_hit2;
    logic [DATA_W-1:0] w_data1;
    logic [DATA_W-1:0] w_data2;

    regbank_fwd_match #(
        .DEPTH   (DEPTH)
    ) u_fwd_match1 (
        .i_qry   (qry_reg1),
        .i_entry (w_ord),
        .i_valid (w_ord_valid),
        .o_hit   (w_hit1),
        .o_data  (w_data1)
    );

    regbank_fwd_match #(
        .DEPTH   (DEPTH)
    ) u_fwd_match2 (
        .i_qry   (qry_reg2),
        .i_entry (w_ord),
        .i_valid (w_ord_valid),
        .o_hit   (w_hit2),
        .o_data  (w_data2)
    );

`ifdef REGBANK_WQ_XZR_EN
    // Register 31 reads as zero from the bank, so it must never be forwarded.
    assign fwd_hit1 = w_hit1 & ~is_zero_reg(qry_reg1);
    assign fwd_hit2 = w_hit2 & ~is_zero_reg(qry_reg2);
`else
    assign fwd_hit1 = w_hit1;
    assign fwd_hit2 = w_hit2;
`endif
    assign fwd_data1 = w_data1;
    assign fwd_data2 = w_data2;

endmodule

// File: tb/tb_regbank_write_queue.sv
// -----------------------------------------------------------------------------
// tb_regbank_write_queue
//
// Directed bench for regbank_write_queue (DEPTH=4). Every accepted request
// pushes its expected bank write into a scoreboard queue; an independent
// monitor on the falling edge pops and compares whenever write is high.
// Handshake, occupancy and forwarding outputs are checked inline against
// hand-computed values. Honors REGBANK_WQ_XZR_EN the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_regbank_write_queue;
    import regbank_pkg::*;

    localparam int DEPTH = 4;

`ifdef REGBANK_WQ_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_reg, mem_reg, write_register, qry_reg1, qry_reg2;
    logic [63:0] alu_data, mem_data, write_data, fwd_data1, fwd_data2;
    logic        write, fwd_hit1, fwd_hit2, empty;
    logic [2:0]  level;

    int n_checks = 0;
    int n_errors = 0;
    wb_entry_t sb [$];

    always #5 clk = ~clk;

    regbank_write_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg        (mem_reg),
        .mem_data       (mem_data),
        .write          (write),
        .write_register (write_register),
        .write_data     (write_data),
        .qry_reg1       (qry_reg1),
        .qry_reg2       (qry_reg2),
        .fwd_hit1       (fwd_hit1),
        .fwd_data1      (fwd_data1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data2      (fwd_data2),
        .level          (level),
        .empty          (empty)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic dropped(input logic [4:0] r);
        return XZR && (r == 5'd31);
    endfunction

    // Called just after a rising edge. Drives one cycle of requests, checks
    // the readies, records accepted requests, then checks level after the edge.
    task automatic step(input logic mv, input logic [4:0] mr, input logic [63:0] md,
                        input logic av, input logic [4:0] ar, input logic [63:0] ad,
                        input logic emr, input logic ear, input int elvl);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        #1;
        check("mem_ready", mem_ready, emr);
        check("alu_ready", alu_ready, ear);
        if (mv && emr && !dropped(mr)) sb.push_back('{addr: mr, data: md});
        if (av && ear && !dropped(ar)) sb.push_back('{addr: ar, data: ad});
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        check("level", 64'(level), 64'(elvl));
        check("empty", empty, elvl == 0);
    endtask

    task automatic idle(input int elvl);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, elvl);
    endtask

    // Scoreboard monitor: every bank write must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && write) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write at %0t",
                         write_register, write_data, $time);
            end else begin
                wb_entry_t e;
                e = sb.pop_front();
                check("write_register", 64'(write_register), 64'(e.addr));
                check("write_data", write_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        qry_reg1 = 5'd0; qry_reg2 = 5'd0;
        #1;
        check("rst_write", write, 1'b0);
        check("rst_level", 64'(level), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        // Reset state
        check("rst_empty", empty, 1'b1);
        check("rst_fwd_hit1", fwd_hit1, 1'b0);
        check("rst_fwd_hit2", fwd_hit2, 1'b0);
        @(posedge clk);
        #1;

        // Single ALU request, written on the following cycle
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hDEAD, 1'b1, 1'b1, 1);
        check("single_write", write, 1'b1);
        check("single_reg", 64'(write_register), 64'd5);
        check("single_data", write_data, 64'hDEAD);
        idle(0);

        // Both producers on an empty queue: load older than ALU
        step(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, 1'b1, 1'b1, 2);
        idle(1);
        idle(0);

        // Saturation: both valid for five cycles, ALU payload changing
        // levels 2,3,4,4,4; ALU refused once only one slot is free
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'(8 + i), 64'h100 + 64'(i),
                 1'b1, 5'(16 + i), 64'h200 + 64'(i),
                 1'b1, (i < 3), (i == 0) ? 2 : (i == 1) ? 3 : 4);
        end
        for (int l = 3; l >= 0; l--) idle(l);

        // Forwarding: reg 7 = 0xA (load, older) then reg 7 = 0xB (ALU, younger)
        qry_reg1 = 5'd7;
        qry_reg2 = 5'd3;
        step(1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 64'hB, 1'b1, 1'b1, 2);
        check("fwd_hit1_two", fwd_hit1, 1'b1);
        check("fwd_data1_two", fwd_data1, 64'hB);
        check("fwd_hit2_miss", fwd_hit2, 1'b0);
        check("fwd_data2_miss", fwd_data2, 64'h0);
        idle(1);
        qry_reg2 = 5'd7;
        #1;
        check("fwd_hit1_head", fwd_hit1, 1'b1);
        check("fwd_data1_head", fwd_data1, 64'hB);
        check("fwd_hit2_head", fwd_hit2, 1'b1);
        check("fwd_data2_head", fwd_data2, 64'hB);
        idle(0);
        check("fwd_hit1_drained", fwd_hit1, 1'b0);
        check("fwd_data1_drained", fwd_data1, 64'h0);

        // Reset with three entries pending: none of them may reach the bank
        step(1'b1, 5'd10, 64'h1010, 1'b1, 5'd11, 64'h1111, 1'b1, 1'b1, 2);
        step(1'b1, 5'd12, 64'h1212, 1'b1, 5'd13, 64'h1313, 1'b1, 1'b1, 3);
        check("pre_rst_write", write, 1'b1);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_write", write, 1'b0);
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_empty", empty, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(0);
        idle(0);
        idle(0);

        // Register 31: dropped as zero register when the option is on
        qry_reg1 = 5'd31;
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'h31, 1'b1, 1'b1, XZR ? 0 : 1);
        check("r31_hit1", fwd_hit1, !XZR);
        check("r31_data1", fwd_data1, XZR ? 64'h0 : 64'h31);
        idle(0);
        idle(0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regbank_write_queue.md
Name: regbank_write_queue

Overview:
- Write-side front end for the 32 x 64-bit CPU register bank.
- Accepts writeback results from two producers, ALU and memory load unit, over valid/ready handshakes.
- Buffers results in a DEPTH-entry in-order FIFO and drives the bank's single write port (write, write_register, write_data) at one write per cycle.
- Provides forwarding lookups so that decode read ports see pending, not-yet-committed values.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
DATA_W, 64, write data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result present
alu_ready  output  1  ALU result accepted this cycle when alu_valid=1
alu_reg  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result present
mem_ready  output  1  load result accepted this cycle when mem_valid=1
mem_reg  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
write  output  1  bank write enable
write_register  output  ADDR_W  bank write index
write_data  output  DATA_W  bank write data
qry_reg1  input  ADDR_W  forwarding query 1 (bank read_register1)
qry_reg2  input  ADDR_W  forwarding query 2 (bank read_register2)
fwd_hit1  output  1  query 1 matches a pending entry
fwd_data1  output  DATA_W  youngest pending data for qry_reg1
fwd_hit2  output  1  query 2 matches a pending entry
fwd_data2  output  DATA_W  youngest pending data for qry_reg2
level  output  $clog2(DEPTH)+1  entries currently held
empty  output  1  level==0

Behaviour:
- Reset (async, asserted): pointers and count go to 0. write=0, empty=1, level=0, fwd_hit1/2=0. Entry storage is not cleared.
- Drain: the bank always accepts. The head entry is presented combinationally (write=!empty, write_register and write_data from the head) and is popped on every clock edge where !empty.
- Latency: a result accepted at edge N is written to the bank at edge N+1 if the queue was empty. Otherwise it is written after all older entries.
- Free slots per cycle: free = DEPTH - level + (level!=0). This accounts for the same-cycle pop.
- mem_ready = (free>=1). It has no dependence on alu_valid.
- alu_ready = (free>=2) | (free>=1 & !mem_valid). The memory unit has priority.
- Both accepted in the same cycle: the mem entry is enqueued older than the ALU entry.
- A push and a pop on the same edge are both honoured. level changes by pushes-minus-pop.
- Full queue (level==DEPTH): free=1, so the queue still accepts one entry because of the pop. It never overflows.
- Pointers wrap modulo DEPTH.
- Forwarding is combinational over all valid entries, including the head being written this cycle. fwd_hitK=1 if any valid entry's reg equals qry_regK. fwd_dataK is the data of the youngest matching entry, otherwise 0.
- Producers may hold valid with changing payload while not ready. Only payloads accepted while ready is high are captured.
- Reset mid-operation: all pending entries are discarded and never written. The bank retains prior contents.

Optional Feature:
REGBANK_WQ_XZR_EN
- Defined: register 31 is the zero register.
  - Requests with reg==31 are handshaken normally (ready unchanged) but not stored.
  - A discarded request still reserves its slot in the free calculation, keeping ready independent of the data.
  - fwd_hitK is forced to 0 when qry_regK==31.
- Undefined: register 31 is handled like any other register.

Decomposition:
- Shared package regbank_pkg:
  - constants NUM_REGS=32, REG_ADDR_W=5, REG_DATA_W=64, ZERO_REG=31
  - typedef wb_entry_t {addr, data}
- One natural sub-module: regbank_fwd_match. It is a priority match over the FIFO entries, youngest first, and is instantiated twice (one per query port).
- The FIFO and handshake logic stay in the top module.

Test Plan:
- Reset, then a single ALU request (reg 5, data 0xDEAD) -> the next cycle shows write=1, write_register=5, write_data=0xDEAD; then empty=1.
- Both valid in the same cycle on an empty queue (mem reg 3 = 0x11, alu reg 4 = 0x22) -> both ready; bank writes reg 3 then reg 4 on consecutive cycles.
- Hold both valid continuously with DEPTH=4 -> level saturates at 4, is never exceeded, and exactly one write per cycle follows the mem-before-alu order; alu_ready=0 while free==1 and mem_valid=1.
- Pending reg 7 = 0xA then reg 7 = 0xB, query qry_reg1=7 -> fwd_hit1=1 with fwd_data1=0xB; after both drain, fwd_hit1=0.
- Assert reset with 3 entries queued -> write drops to 0 immediately (async), level=0, and no queued entry reaches the bank after release.
- With REGBANK_WQ_XZR_EN, an ALU request to reg 31 -> alu_ready=1, no bank write follows, and fwd_hit1=0 for qry_reg1=31. Without the macro, the reg 31 write occurs.
